// File: rtl/sram_access_ctrl_if.sv
// Request/response handshake between the CPU datapath (master) and the SRAM access controller (slave).
interface sram_access_ctrl_if #(
  parameter int N = 8
);
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic [N-1:0] req_len;
  logic         resp_valid;
  logic [N-1:0] resp_rdata;
  logic         busy;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_len,
    input  req_ready, resp_valid, resp_rdata, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_len,
    output req_ready, resp_valid, resp_rdata, busy
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// Single-outstanding load/store/fill sequencer driving a registered-read SRAM.
module sram_access_ctrl #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_access_ctrl_if.slave bus,
  output logic             SRAM_readEnable,
  output logic             SRAM_writeEnable,
  output logic [N-1:0]     SRAM_address,
  output logic [N-1:0]     SRAM_data_in,
  input  logic [N-1:0]     SRAM_data
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAPT  = 3'd2,
    WR       = 3'd3,
    FILL     = 3'd4
  } state_t;

  localparam logic [1:0]   OP_WRITE = 2'b01;
  localparam logic [1:0]   OP_FILL  = 2'b10;
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

  state_t       state_reg;
  logic [N-1:0] remaining_reg;
  logic         resp_valid_reg;
  logic [N-1:0] resp_rdata_reg;
  logic         accept;

  // Gated with rst_n so the requester never sees ready while reset is held.
  assign bus.req_ready  = (state_reg == IDLE) && rst_n;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign accept         = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      remaining_reg    <= '0;
      resp_valid_reg   <= 1'b0;
      resp_rdata_reg   <= '0;
      SRAM_readEnable  <= 1'b0;
      SRAM_writeEnable <= 1'b0;
      SRAM_address     <= '0;
      SRAM_data_in     <= '0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            case (bus.req_op)
              OP_WRITE: begin
                state_reg        <= WR;
                SRAM_writeEnable <= 1'b1;
                SRAM_address     <= bus.req_addr;
                SRAM_data_in     <= bus.req_wdata;
              end
              OP_FILL: begin
                // A zero-length fill completes without touching the SRAM.
                if (bus.req_len == '0) begin
                  resp_valid_reg <= 1'b1;
                end else begin
                  state_reg        <= FILL;
                  SRAM_writeEnable <= 1'b1;
                  SRAM_address     <= bus.req_addr;
                  SRAM_data_in     <= bus.req_wdata;
                  remaining_reg    <= bus.req_len;
                end
              end
              default: begin
                state_reg       <= RD_ISSUE;
                SRAM_readEnable <= 1'b1;
                SRAM_address    <= bus.req_addr;
              end
            endcase
          end
        end
        RD_ISSUE: begin
          SRAM_readEnable <= 1'b0;
          state_reg       <= RD_CAPT;
        end
        RD_CAPT: begin
          resp_rdata_reg <= SRAM_data;
          resp_valid_reg <= 1'b1;
          state_reg      <= IDLE;
        end
        WR: begin
          SRAM_writeEnable <= 1'b0;
          resp_valid_reg   <= 1'b1;
          state_reg        <= IDLE;
        end
        FILL: begin
          // Address wraps naturally at 2**N; it is left on the last word written.
          if (remaining_reg == ONE) begin
            SRAM_writeEnable <= 1'b0;
            resp_valid_reg   <= 1'b1;
            state_reg        <= IDLE;
          end else begin
            SRAM_address  <= SRAM_address + ONE;
            remaining_reg <= remaining_reg - ONE;
          end
        end
        default: begin
          SRAM_readEnable  <= 1'b0;
          SRAM_writeEnable <= 1'b0;
          state_reg        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Request-side controller sitting directly upstream of the data SRAM.
- Converts single-outstanding load/store/fill requests from the CPU datapath into SRAM_readEnable / SRAM_writeEnable / SRAM_address / SRAM_data_in strobes.
- Captures the SRAM's one-cycle registered read data and returns it with a valid pulse.
- Fill op writes one value over an address range, used for stack/buffer clearing.

Parameters:
N, 8, data and address width; must match the SRAM's N (memory depth 2**N).

Ports:
clk  input  1  rising-edge clock shared with SRAM
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept; high only in IDLE and rst_n high
req_op  input  2  00 read, 01 write, 10 fill, 11 reserved (treated as read)
req_addr  input  N  start address
req_wdata  input  N  write/fill data
req_len  input  N  fill word count; 0 = no-op
resp_valid  output  1  one-cycle completion pulse, all ops
resp_rdata  output  N  read data, valid with resp_valid for reads, held otherwise
busy  output  1  state != IDLE
SRAM_readEnable  output  1  to SRAM
SRAM_writeEnable  output  1  to SRAM
SRAM_address  output  N  to SRAM
SRAM_data_in  output  N  to SRAM
SRAM_data  input  N  registered read data from SRAM

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0: req_ready, resp_valid, resp_rdata, busy, both enables, address, data_in. An in-flight op is aborted with no resp_valid. SRAM contents are untouched. Sync release; req_ready rises the first cycle rst_n is high.
- All SRAM-side outputs and resp_* are registered. req_ready and busy are decoded from the state register.
- Accept = req_valid && req_ready at a clk edge (E0). Inputs are sampled only at acceptance.
- States:
  - IDLE
  - RD_ISSUE: readEnable=1, address=addr.
  - RD_CAPT: readEnable=0, waiting for SRAM_data.
  - WR: writeEnable=1, address, data_in.
  - FILL: writeEnable=1, address incrementing.
- Read: E0 -> RD_ISSUE. The SRAM samples at E1 -> RD_CAPT. At E2, resp_rdata <= SRAM_data, resp_valid=1, state -> IDLE. resp_valid is high in the cycle after E2. Accept-to-resp latency is 2 cycles.
- Write: E0 -> WR. The SRAM writes at E1, then resp_valid=1 and state -> IDLE. Latency is 1 cycle. resp_rdata is unchanged.
- Fill, len L>0: E0 -> FILL with address=addr, remaining=L.
  - Each edge in FILL writes one word, then increments the address modulo 2**N (wraps 2**N-1 -> 0) and decrements remaining.
  - On the edge that writes the L-th word: writeEnable drops, resp_valid=1, state -> IDLE.
  - L writes occupy L consecutive cycles; ack arrives after edge E_L.
- Fill, L=0: no SRAM access. resp_valid=1 the cycle after E0, stays IDLE.
- readEnable and writeEnable are never high in the same cycle (the SRAM gives read priority). Address and data_in hold their last values when both enables are low.
- Back-to-back: the cycle resp_valid is high, state is IDLE and req_ready=1, so a new request may be accepted on that edge. Sustained throughput: read one per 3 cycles, write one per 2.
- resp_valid is exactly one cycle; there is no response backpressure.
- req_valid while busy is ignored; the requester must hold it until accepted.

Test Plan:
- Reset mid-read: after reset, write 0x5A to 0x10, then read 0x10. Required: writeEnable pulses 1 cycle; resp_valid 1 cycle later. Read resp_valid 2 cycles after accept with resp_rdata=0x5A; readEnable high exactly 1 cycle.
- Back-to-back: hold req_valid for write 0x03<-0x11, then read 0x03, then read 0x04 (initial 0x00). Required: each accepted the cycle resp_valid pulses; resp_rdata 0x11 then 0x00; enables never both high.
- Fill with wrap: addr 0xFE, len 3, data 0xAA. Required: writes at 0xFE, 0xFF, 0x00 in 3 consecutive cycles; resp_valid after the third; reading 0xFD returns 0x00 and 0x00 returns 0xAA.
- Fill len 0 at 0x20: no enable asserted; resp_valid the next cycle; 0x20 is unchanged.
- Reset mid-fill: assert rst_n low during the 2nd word of a len-8 fill at 0x40. Required: enables and busy fall immediately; no resp_valid; after release req_ready=1. Reads return the fill value at 0x40..0x41 (0x41 only if its write edge preceded reset) and 0x00 at 0x42..0x47.
- Busy gating: req_valid pulsed during a fill. Required: not accepted, req_ready=0 throughout; busy=1 exactly until the resp_valid cycle.
